// File: rtl/face_pkg.sv
// Shared geometry, word widths and FSM state type for the face-detection scale pipeline.
package face_pkg;

  localparam int IMG_W_MAX = 640;
  localparam int IMG_H_MAX = 480;
  localparam int PIX_W     = 8;
  localparam int II_W      = 27;
  localparam int SQ_W      = 35;
  localparam int ADDR_W    = 19;
  localparam int MIN_W     = 24;
  localparam int COL_W     = 10;
  localparam int ROW_W     = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERR
  } state_t;

  // One row-buffer entry: running column integrals for both sums.
  typedef struct packed {
    logic [SQ_W-1:0] sq;
    logic [II_W-1:0] ii;
  } rb_word_t;

endpackage

// File: rtl/ii_row_ram.sv
// One-row buffer of column integrals: 1R1W, synchronous read with one cycle of latency.
module ii_row_ram
  import face_pkg::*;
(
  input  logic             clk,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_addr,
  output rb_word_t         rd_data,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  rb_word_t         wr_data
);

  rb_word_t mem [IMG_W_MAX];

  // NOTE: no reset on the array or read register so this maps onto block RAM; row 0 never consumes its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/integral_image_builder.sv
// Streams scaled pixels into integral and squared-integral words, one memory write per pixel,
// using a two-stage pipeline around a single-row buffer of column integrals.
module integral_image_builder
  import face_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [COL_W-1:0]  img_width,
  input  logic [ROW_W-1:0]  img_height,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              ii_we,
  output logic [ADDR_W-1:0] ii_addr,
  output logic [II_W-1:0]   ii_data,
  output logic [SQ_W-1:0]   sq_data,
  output logic              done,
  output logic              cfg_err,
  output logic              drop_err
);

  state_t state, state_nxt;

  logic              en_d;
  logic [COL_W-1:0]  w_reg, col_cnt, s1_col;
  logic [ROW_W-1:0]  h_reg, row_cnt, s1_row;
  logic [ADDR_W-1:0] addr_cnt, s1_addr;
  logic              all_taken, s1_valid, s1_last, ii_last, fwd_hit;
  logic [II_W-1:0]   row_sum;
  logic [SQ_W-1:0]   row_sq;
  logic [2*PIX_W-1:0] pix_sq;
  rb_word_t          rd_word, fwd_word, prior, s2_word;

  logic start, geom_ok, accept, col_last, last_pix;

  assign start    = en && !en_d;
  assign geom_ok  = (img_width >= COL_W'(MIN_W)) && (img_width <= COL_W'(IMG_W_MAX)) &&
                    (img_height != '0) && (img_height <= ROW_W'(IMG_H_MAX));
  assign accept   = (state == RUN) && pix_valid && !all_taken;
  assign col_last = (col_cnt == w_reg - COL_W'(1));
  assign last_pix = col_last && (row_cnt == h_reg - ROW_W'(1));
  assign pix_sq   = (2*PIX_W)'(pix_data) * (2*PIX_W)'(pix_data);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    cfg_err   = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = geom_ok ? RUN : ERR;
      RUN:     if (ii_we && ii_last) state_nxt = DONE;
      default: state_nxt = state;
    endcase
    if (!en) state_nxt = IDLE;
    done    = (state == DONE);
    cfg_err = (state == ERR);
  end

  // Stage 2: add the column integral of the row above; forward when the row buffer is stale.
  always_comb begin
    prior = '0;
    if (s1_row != '0) prior = fwd_hit ? fwd_word : rd_word;
    s2_word.ii = row_sum + prior.ii;
    s2_word.sq = row_sq + prior.sq;
  end

  ii_row_ram u_row_ram (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (col_cnt),
    .rd_data (rd_word),
    .wr_en   (s1_valid && en),
    .wr_addr (s1_col),
    .wr_data (s2_word)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every stage sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_d      <= 1'b0;
      w_reg     <= '0;
      h_reg     <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      addr_cnt  <= '0;
      all_taken <= 1'b0;
      row_sum   <= '0;
      row_sq    <= '0;
      s1_valid  <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_addr   <= '0;
      s1_last   <= 1'b0;
      fwd_hit   <= 1'b0;
      fwd_word  <= '0;
      ii_we     <= 1'b0;
      ii_last   <= 1'b0;
      ii_addr   <= '0;
      ii_data   <= '0;
      sq_data   <= '0;
      drop_err  <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        s1_valid  <= 1'b0;
        ii_we     <= 1'b0;
        ii_last   <= 1'b0;
        fwd_hit   <= 1'b0;
        all_taken <= 1'b0;
        drop_err  <= 1'b0;
      end else begin
        if (start) begin
          w_reg     <= img_width;
          h_reg     <= img_height;
          col_cnt   <= '0;
          row_cnt   <= '0;
          addr_cnt  <= '0;
          all_taken <= 1'b0;
        end

        s1_valid <= accept;
        fwd_hit  <= accept && s1_valid && (col_cnt == s1_col);
        fwd_word <= s2_word;
        if (accept) begin
          row_sum  <= (col_cnt == '0) ? II_W'(pix_data) : row_sum + II_W'(pix_data);
          row_sq   <= (col_cnt == '0) ? SQ_W'(pix_sq) : row_sq + SQ_W'(pix_sq);
          s1_col   <= col_cnt;
          s1_row   <= row_cnt;
          s1_addr  <= addr_cnt;
          s1_last  <= last_pix;
          addr_cnt <= addr_cnt + ADDR_W'(1);
          if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ROW_W'(1);
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
          if (last_pix) all_taken <= 1'b1;
        end

        ii_we   <= s1_valid;
        ii_last <= s1_valid && s1_last;
        if (s1_valid) begin
          ii_addr <= s1_addr;
          ii_data <= s2_word.ii;
          sq_data <= s2_word.sq;
        end

        if (((state == DONE) || (state == ERR)) && pix_valid) drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_integral_image_builder.sv
// Self-checking bench: random pixel frames against a 2-D prefix-sum reference model.
module tb_integral_image_builder;
  import face_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [COL_W-1:0]  img_width = '0;
  logic [ROW_W-1:0]  img_height = '0;
  logic              pix_valid = 1'b0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              ii_we;
  logic [ADDR_W-1:0] ii_addr;
  logic [II_W-1:0]   ii_data;
  logic [SQ_W-1:0]   sq_data;
  logic              done, cfg_err, drop_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  integral_image_builder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .img_width  (img_width),
    .img_height (img_height),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .ii_we      (ii_we),
    .ii_addr    (ii_addr),
    .ii_data    (ii_data),
    .sq_data    (sq_data),
    .done       (done),
    .cfg_err    (cfg_err),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              addr;
    longint unsigned ii;
    longint unsigned sq;
    int              due;
  } exp_t;

  exp_t            exp_q[$];
  int unsigned     pix_arr[];
  longint unsigned m_ii[];
  longint unsigned m_sq[];

  // Reference integral image by inclusion-exclusion over the whole 2-D pixel array.
  function automatic void build_model(int w, int h, int mode, int cval);
    pix_arr = new[w*h];
    m_ii    = new[w*h];
    m_sq    = new[w*h];
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int idx = r*w + c;
        int unsigned p;
        longint unsigned a, s;
        p = (mode == 0) ? cval : (mode == 1) ? ((r*w + c) % 256) : $urandom_range(0, 255);
        pix_arr[idx] = p;
        a = p;
        s = longint'(p) * longint'(p);
        if (r > 0) begin a += m_ii[idx-w]; s += m_sq[idx-w]; end
        if (c > 0) begin a += m_ii[idx-1]; s += m_sq[idx-1]; end
        if (r > 0 && c > 0) begin a -= m_ii[idx-w-1]; s -= m_sq[idx-w-1]; end
        m_ii[idx] = a;
        m_sq[idx] = s;
      end
    end
  endfunction

  task automatic start_frame(input int w, input int h);
    @(negedge clk);
    en = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    img_width  = COL_W'(w);
    img_height = ROW_W'(h);
    en = 1'b1;
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input int cval,
                           input int gap_pct, input int abort_at,
                           output int last_addr, output longint unsigned last_ii,
                           output longint unsigned last_sq);
    int   sent = 0;
    int   seen = 0;
    int   budget;
    bit   fin = 1'b0;
    bit   fin_pending = 1'b0;
    bit   aborting = 1'b0;
    exp_t e;
    logic [63:0] oi, os;
    build_model(w, h, mode, cval);
    exp_q.delete();
    last_addr = -1;
    last_ii = 0;
    last_sq = 0;
    start_frame(w, h);
    budget = w*h*((gap_pct > 0) ? 4 : 1) + 100;
    while (!fin && budget > 0) begin
      @(negedge clk);
      budget--;
      if (aborting) begin
        checks++;
        if (ii_we !== 1'b0) begin
          errors++;
          $display("FAIL abort_we_low got ii_we=%b expected 0", ii_we);
        end
        fin = 1'b1;
      end else if (fin_pending) begin
        checks++;
        if (done !== 1'b1 || ii_we !== 1'b0) begin
          errors++;
          $display("FAIL done_after_last got done=%b ii_we=%b expected done=1 ii_we=0", done, ii_we);
        end
        fin = 1'b1;
      end else if (ii_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d expected no write", ii_addr);
        end else begin
          e  = exp_q.pop_front();
          oi = 64'(ii_data);
          os = 64'(sq_data);
          if (ii_addr !== ADDR_W'(e.addr) || oi !== e.ii || os !== e.sq || cyc != e.due) begin
            errors++;
            $display("FAIL pixel_write got addr=%0d ii=%0d sq=%0d cyc=%0d expected addr=%0d ii=%0d sq=%0d cyc=%0d",
                     ii_addr, oi, os, cyc, e.addr, e.ii, e.sq, e.due);
          end
          last_addr = int'(ii_addr);
          last_ii   = oi;
          last_sq   = os;
          seen++;
          if (seen == w*h) begin
            checks++;
            if (done !== 1'b0) begin
              errors++;
              $display("FAIL done_early got done=%b expected 0", done);
            end
            fin_pending = 1'b1;
          end
        end
      end

      pix_valid = 1'b0;
      if (!fin) begin
        if (abort_at >= 0 && sent == abort_at && !aborting) begin
          en = 1'b0;
          aborting = 1'b1;
        end else if (!aborting && sent < w*h && $urandom_range(0, 99) >= gap_pct) begin
          pix_valid = 1'b1;
          pix_data  = PIX_W'(pix_arr[sent]);
          exp_q.push_back('{sent, m_ii[sent], m_sq[sent], cyc + 2});
          sent++;
        end
      end
    end
    pix_valid = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got %0d writes expected %0d", seen, w*h);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ii_we, ii_addr, ii_data, sq_data, done, cfg_err, drop_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%0d ii=%0d sq=%0d done=%b cfg=%b drop=%b expected all 0",
               ii_we, ii_addr, ii_data, sq_data, done, cfg_err, drop_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ones();
    int la;
    longint unsigned li, ls;
    run_frame(24, 2, 0, 1, 0, -1, la, li, ls);
    checks++;
    if (la != 47 || li != 48 || ls != 48) begin
      errors++;
      $display("FAIL ones_last got addr=%0d ii=%0d sq=%0d expected 47 48 48", la, li, ls);
    end
  endtask

  task automatic test_max_value();
    int la;
    longint unsigned li, ls;
    run_frame(640, 64, 0, 255, 0, -1, la, li, ls);
    checks++;
    if (la != 40959 || li != 64'd10444800 || ls != 64'd2663424000) begin
      errors++;
      $display("FAIL max_last got addr=%0d ii=%0d sq=%0d expected 40959 10444800 2663424000", la, li, ls);
    end
  endtask

  task automatic test_gaps();
    int la;
    longint unsigned li, ls;
    run_frame(24, 3, 1, 0, 30, -1, la, li, ls);
    for (int k = 0; k < 3; k++)
      run_frame($urandom_range(24, 64), $urandom_range(1, 4), 2, 0, 20, -1, la, li, ls);
  endtask

  task automatic test_abort_restart();
    int la;
    longint unsigned li, ls;
    run_frame(24, 3, 1, 0, 0, 34, la, li, ls);
    run_frame(32, 2, 2, 0, 10, -1, la, li, ls);
    checks++;
    if (la != 63) begin
      errors++;
      $display("FAIL restart_last_addr got %0d expected 63", la);
    end
  endtask

  task automatic test_cfg_err();
    int gw[3] = '{23, 641, 24};
    int gh[3] = '{5, 5, 0};
    for (int k = 0; k < 3; k++) begin
      start_frame(gw[k], gh[k]);
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1 || ii_we !== 1'b0 || drop_err !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_set w=%0d h=%0d got cfg=%b we=%b drop=%b expected 1 0 0",
                 gw[k], gh[k], cfg_err, ii_we, drop_err);
      end
      pix_valid = 1'b1;
      pix_data  = PIX_W'($urandom_range(0, 255));
      @(negedge clk);
      pix_valid = 1'b0;
      checks++;
      if (drop_err !== 1'b1 || ii_we !== 1'b0 || cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL cfg_drop got drop=%b we=%b cfg=%b expected 1 0 1", drop_err, ii_we, cfg_err);
      end
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || drop_err !== 1'b0) begin
        errors++;
        $display("FAIL cfg_clear got cfg=%b drop=%b expected 0 0", cfg_err, drop_err);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame(24, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = PIX_W'($urandom_range(1, 255));
    end
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ii_we, ii_addr, ii_data, sq_data, done, cfg_err, drop_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got we=%b addr=%0d ii=%0d sq=%0d done=%b cfg=%b drop=%b expected all 0",
               ii_we, ii_addr, ii_data, sq_data, done, cfg_err, drop_err);
    end
    rst_n = 1'b1;
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ii_we !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got we=%b done=%b cfg=%b expected 0 0 0", ii_we, done, cfg_err);
    end
  endtask

  task automatic test_drop_after_done();
    int la;
    longint unsigned li, ls;
    run_frame(24, 1, 2, 0, 0, -1, la, li, ls);
    @(negedge clk);
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    checks++;
    if (drop_err !== 1'b1 || done !== 1'b1 || ii_we !== 1'b0) begin
      errors++;
      $display("FAIL drop_after_done got drop=%b done=%b we=%b expected 1 1 0", drop_err, done, ii_we);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL en_low_clear got drop=%b done=%b expected 0 0", drop_err, done);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_max_value();
    test_gaps();
    test_abort_restart();
    test_cfg_err();
    test_reset_mid_frame();
    test_drop_after_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
